// File: rtl/uart_rx_keypad_if.sv
// Signal bundle between the keypad return-path receiver and its host-side logic.
// The receiver takes the slave modport; whatever drives the serial line takes master.
interface uart_rx_keypad_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [3:0] key_code;
  logic       key_valid;
  logic       pkt_err;
  logic       busy;

  modport master (
    output uart_rx,
    input  rx_data, rx_valid, frame_err, key_code, key_valid, pkt_err, busy
  );

  modport slave (
    input  uart_rx,
    output rx_data, rx_valid, frame_err, key_code, key_valid, pkt_err, busy
  );
endinterface

// File: rtl/uart_rx_keypad.sv
// 8N1 UART receiver plus a two-byte key packet decoder ("header, key char" -> 4-bit keypad code).
// Byte strobes come out one cycle after the stop sample; key strobes follow one cycle later.
module uart_rx_keypad #(
  parameter int         DELAY_FRAMES = 2812,
  parameter logic [7:0] HEADER       = 8'h32
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_keypad_if.slave  bus
);

  localparam int             CW       = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(DELAY_FRAMES / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    PKT_WAIT_HDR,
    PKT_WAIT_KEY
  } pkt_state_t;

  logic [1:0]    sync_q, sync_d;
  logic          rxs;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  pkt_state_t    pkt_state_q, pkt_state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          pkt_err_q, pkt_err_d;
  logic [4:0]    key_dec;

  // Returns {valid, code}; only the sixteen keypad legends are accepted.
  function automatic logic [4:0] decode_key(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    case (c)
      8'h30: r = {1'b1, 4'h0};
      8'h31: r = {1'b1, 4'h1};
      8'h32: r = {1'b1, 4'h2};
      8'h33: r = {1'b1, 4'h3};
      8'h34: r = {1'b1, 4'h4};
      8'h35: r = {1'b1, 4'h5};
      8'h36: r = {1'b1, 4'h6};
      8'h37: r = {1'b1, 4'h7};
      8'h38: r = {1'b1, 4'h8};
      8'h39: r = {1'b1, 4'h9};
      8'h41: r = {1'b1, 4'hA};
      8'h42: r = {1'b1, 4'hB};
      8'h43: r = {1'b1, 4'hC};
      8'h44: r = {1'b1, 4'hD};
      8'h23: r = {1'b1, 4'hE};
      8'h2A: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign rxs = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], bus.uart_rx};
  end

  // Receiver: the START check at half a bit re-centres every later sample mid-bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) begin
          cnt_d      = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = 3'd0;
          if (rxs) rx_state_d = RX_IDLE;
          else     rx_state_d = RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxs) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Packet decoder: in WAIT_KEY a "2" is a key, never a fresh header.
  always_comb begin
    pkt_state_d = pkt_state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    key_dec     = decode_key(rx_data_q);
    case (pkt_state_q)
      PKT_WAIT_HDR: begin
        if (rx_valid_q && rx_data_q == HEADER) pkt_state_d = PKT_WAIT_KEY;
      end
      PKT_WAIT_KEY: begin
        if (rx_valid_q) begin
          pkt_state_d = PKT_WAIT_HDR;
          if (key_dec[4]) begin
            key_code_d  = key_dec[3:0];
            key_valid_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end else if (frame_err_q) begin
          pkt_state_d = PKT_WAIT_HDR;
          pkt_err_d   = 1'b1;
        end
      end
      default: pkt_state_d = PKT_WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_state_q <= PKT_WAIT_HDR;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      pkt_state_q <= pkt_state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.busy      = (rx_state_q != RX_IDLE);

endmodule

// File: doc/uart_rx_keypad.md
# uart_rx_keypad

UART receiver and packet decoder for the keypad interface. It deserialises 8N1 frames on `uart_rx` at 9600 baud from the 27 MHz system clock and delivers each byte with a one-cycle strobe. It parses the two-byte key packet, header `"2"` followed by a key character, back into the 4-bit keypad code used by the keypad encoder. It sits beside the keypad interface as the return path from the host.

## Interface
- `DELAY_FRAMES`, default 2812: clock cycles per bit (27,000,000 / 9600).
- `HEADER`, default 8'h32: packet header byte, ASCII `"2"`.

- `clk`, input, 1: system clock, 27 MHz.
- `rst`, input, 1: reset, synchronous and active-high.
- `uart_rx`, input, 1: asynchronous serial line; idles high.
- `rx_data`, output, 8: last good byte received; holds its value between strobes.
- `rx_valid`, output, 1: one-cycle strobe; `rx_data` has just been updated.
- `frame_err`, output, 1: one-cycle strobe; stop bit was sampled low.
- `key_code`, output, 4: last decoded key code; holds its value between strobes.
- `key_valid`, output, 1: one-cycle strobe; `key_code` has just been updated.
- `pkt_err`, output, 1: one-cycle strobe; the key byte was invalid or its frame failed.
- `busy`, output, 1: high whenever the receiver is not in IDLE.

## Operation
- Input conditioning: `uart_rx` passes through a two-flop synchroniser. Both flops reset to 1. All logic uses the synchronised signal `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. It uses a bit counter (`$clog2(DELAY_FRAMES)` bits) and a 3-bit bit index.
- IDLE: when `rxs` = 0, clear the counter and go to START.
- START: at counter = DELAY_FRAMES/2 − 1, sample `rxs`.
  - If `rxs` = 1, the start was false: return to IDLE with no strobe.
  - Otherwise clear the counter and go to DATA.
- DATA: at counter = DELAY_FRAMES − 1, sample `rxs` into shift bit[index], LSB first. After index 7, go to STOP.
- STOP: at counter = DELAY_FRAMES − 1, sample `rxs`.
  - If `rxs` = 1: load `rx_data`, pulse `rx_valid`, go to IDLE.
  - If `rxs` = 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs` = 1, then go to IDLE. This state handles line breaks.
- Packet FSM states: WAIT_HDR, WAIT_KEY. It acts only on `rx_valid` and `frame_err`.
  - In WAIT_HDR, a byte equal to HEADER moves to WAIT_KEY. Any other byte is ignored silently.
  - In WAIT_KEY, a valid key character updates `key_code`, pulses `key_valid`, and returns to WAIT_HDR. `"2"` here is key 2, not a new header.
  - In WAIT_KEY, an invalid character pulses `pkt_err` and returns to WAIT_HDR.
  - A `frame_err` in WAIT_KEY pulses `pkt_err` and returns to WAIT_HDR. A `frame_err` in WAIT_HDR changes nothing.
- Key map, character to code:
  - `"1"`→1, `"2"`→2, `"3"`→3, `"A"`→A
  - `"4"`→4, `"5"`→5, `"6"`→6, `"B"`→B
  - `"7"`→7, `"8"`→8, `"9"`→9, `"C"`→C
  - `"*"`→F, `"0"`→0, `"#"`→E, `"D"`→D
  - Lowercase letters are invalid.

## Timing
- Reset values:
  - `rx_data` = 0, `key_code` = 0.
  - All strobes = 0, `busy` = 0.
  - FSMs in IDLE and WAIT_HDR; synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame on the next edge, with no strobes. After reset is released, the receiver waits for a fresh falling edge. A line that is still low is seen as a start and rejected or reframed by the START check.
- Start detection: 2 cycles after `uart_rx` falls, due to the synchroniser.
- Sample points: the start check happens DELAY_FRAMES/2 cycles after detection. Each later sample comes DELAY_FRAMES cycles after the previous one, so each sample lands mid-bit.
- `rx_valid` and `frame_err` rise on the clock edge after the stop-bit sample, for exactly one cycle. The receiver is in IDLE in that same cycle, so a start bit immediately after the stop bit is accepted.
- `key_valid` and `pkt_err` rise one cycle after the `rx_valid` or `frame_err` that caused them, for exactly one cycle.
- `rx_valid` and `frame_err` are mutually exclusive. `key_valid` and `pkt_err` are mutually exclusive.
- Glitches shorter than DELAY_FRAMES/2 cycles produce no output.

## Test plan
- Send 0x32 then 0x35 (`"25"`) back to back at 2812 cycles/bit → `rx_valid` ×2 with 0x32 then 0x35; one `key_valid` with `key_code` = 5.
- Send `"2*"`, then `"2#"` → `key_code` = F, then E; two `key_valid` pulses, no `pkt_err`.
- Send a lone 0x37, then `"2X"` → `rx_valid` for 0x37 with no `key_valid`; for `"2X"`, `pkt_err` once and `key_code` unchanged.
- Drive `uart_rx` low for 1000 cycles, then high → no strobes; `busy` high for about 1406 cycles, then IDLE.
- Send 0x41 with the stop bit forced low for 3 bit times → one `frame_err`, no `rx_valid`, `rx_data` unchanged; a following `"2B"` decodes to B.
- Assert `rst` for 1 cycle in the middle of bit 4 → no strobes, all outputs at reset values; a following `"2D"` decodes to D.
